// File: rtl/conv_window_sched.sv
// Window address sequencer for conv_mac: walks every output position and issues its filter taps.
// Optional CONV_SCHED_PERF_EN adds a saturating stall_cnt output counting MAC back-pressure cycles.
module conv_window_sched #(
    parameter int FILTER_SIZE   = 3,
    parameter int OFMAP_SIZE    = 4,
    parameter int IFMAP_SIZE    = 6,
    parameter int ADDR_W        = 8,
    parameter int IP_DATA_WIDTH = 8,
    parameter int TAP_W         = $clog2(FILTER_SIZE * FILTER_SIZE),
    parameter int WIN_W         = $clog2(OFMAP_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic [2*IP_DATA_WIDTH-1:0] tap_data,
    output logic                       tap_valid,
    input  logic                       mac_ready,
    output logic [2*IP_DATA_WIDTH-1:0] tap_out,
    output logic [TAP_W-1:0]           tap_idx,
    output logic                       tap_last,
    output logic [WIN_W-1:0]           win_row,
    output logic [WIN_W-1:0]           win_col
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int TAPS = FILTER_SIZE * FILTER_SIZE;
    localparam int FC_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int DW   = 2 * IP_DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [FC_W-1:0]  fc_q, fc_d, fr_q, fr_d;
    logic [WIN_W-1:0] ocol_q, ocol_d, orow_q, orow_d;
    logic             tap_valid_q, tap_valid_d;
    logic             pend_q, pend_d;
    logic [DW-1:0]    data_q, data_d;
    logic [TAP_W-1:0] idx_q, idx_d;
    logic [WIN_W-1:0] row_q, row_d, col_q, col_d;
    logic             fc_max, fr_max, ocol_max, orow_max, last_issue;

    assign fc_max     = (fc_q == FC_W'(FILTER_SIZE - 1));
    assign fr_max     = (fr_q == FC_W'(FILTER_SIZE - 1));
    assign ocol_max   = (ocol_q == WIN_W'(OFMAP_SIZE - 1));
    assign orow_max   = (orow_q == WIN_W'(OFMAP_SIZE - 1));
    assign rd_en      = (state_q == S_ISSUE) && (!tap_valid_q || mac_ready);
    assign last_issue = rd_en && fc_max && fr_max && ocol_max && orow_max;

    assign rd_addr = ADDR_W'((32'(orow_q) + 32'(fr_q)) * IFMAP_SIZE + 32'(ocol_q) + 32'(fc_q));

    // Buffer data is live only in the cycle after the read; capture it so the tap survives a stall.
    assign tap_out   = pend_q ? tap_data : data_q;
    assign tap_valid = tap_valid_q;
    assign tap_idx   = idx_q;
    assign tap_last  = (idx_q == TAP_W'(TAPS - 1));
    assign win_row   = row_q;
    assign win_col   = col_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !abort) state_d = S_ISSUE;
            S_ISSUE: if (abort) state_d = S_IDLE;
                     else if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (abort) state_d = S_IDLE;
                     else if (tap_valid_q && mac_ready) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fc_d   = fc_q;
        fr_d   = fr_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (abort) begin
            fc_d   = '0;
            fr_d   = '0;
            ocol_d = '0;
            orow_d = '0;
        end else if (rd_en) begin
            fc_d = fc_max ? '0 : fc_q + FC_W'(1);
            if (fc_max) begin
                fr_d = fr_max ? '0 : fr_q + FC_W'(1);
                if (fr_max) begin
                    ocol_d = ocol_max ? '0 : ocol_q + WIN_W'(1);
                    if (ocol_max) orow_d = orow_max ? '0 : orow_q + WIN_W'(1);
                end
            end
        end
    end

    // Tags are latched at issue time so they travel with the tap through the output stage.
    always_comb begin
        pend_d      = rd_en && !abort;
        data_d      = pend_q ? tap_data : data_q;
        tap_valid_d = tap_valid_q && !mac_ready;
        idx_d       = idx_q;
        row_d       = row_q;
        col_d       = col_q;
        if (abort) begin
            tap_valid_d = 1'b0;
        end else if (rd_en) begin
            tap_valid_d = 1'b1;
            idx_d       = TAP_W'(32'(fr_q) * FILTER_SIZE + 32'(fc_q));
            row_d       = orow_q;
            col_d       = ocol_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fc_q        <= '0;
            fr_q        <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            tap_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            data_q      <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            fr_q        <= fr_d;
            ocol_q      <= ocol_d;
            orow_q      <= orow_d;
            tap_valid_q <= tap_valid_d;
            pend_q      <= pend_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_IDLE && start && !abort)
            stall_cnt_d = '0;
        else if ((state_q == S_ISSUE || state_q == S_DRAIN) && tap_valid_q && !mac_ready
                 && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched with a tap-order reference model checked every cycle.
module tb_conv_window_sched;

    localparam int FS = 3;
    localparam int OS = 4;
    localparam int IS = 6;
    localparam int N  = OS * OS * FS * FS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, mac_ready;
    logic        busy, done, rd_en, tap_valid, tap_last;
    logic [7:0]  rd_addr;
    logic [15:0] tap_data, tap_out;
    logic [3:0]  tap_idx;
    logic [1:0]  win_row, win_col;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int issue_ptr = 0;
    int acc_ptr = 0;

    int rd_count, rd_first, last_addr, done_count, done_cyc;
    int busy_first, busy_last, tv_first, tv_last;
    int addr_lo, addr_hi, out_lo, out_hi;
    int fa[10];

    logic        prev_hold = 1'b0;
    logic [15:0] prev_out;
    logic [3:0]  prev_idx;
    logic [1:0]  prev_row, prev_col;

    conv_window_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .tap_data  (tap_data),
        .tap_valid (tap_valid),
        .mac_ready (mac_ready),
        .tap_out   (tap_out),
        .tap_idx   (tap_idx),
        .tap_last  (tap_last),
        .win_row   (win_row),
        .win_col   (win_col)
`ifdef CONV_SCHED_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Ifmap buffer: word at address a holds {A5, a}; unread cycles return a poison value.
    always @(posedge clk) tap_data <= rd_en ? {8'hA5, rd_addr} : 16'hDEAD;

    function automatic int exp_addr(input int p);
        int orow, ocol, fr, fc;
        orow = p / (FS * FS * OS);
        ocol = (p / (FS * FS)) % OS;
        fr   = (p % (FS * FS)) / FS;
        fc   = p % FS;
        return (orow + fr) * IS + ocol + fc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_rd_en"}, 32'(rd_en), 0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
        checkOutput({tag, "_tap_valid"}, 32'(tap_valid), 0);
        checkOutput({tag, "_tap_out"}, 32'(tap_out), 0);
        checkOutput({tag, "_tap_idx"}, 32'(tap_idx), 0);
        checkOutput({tag, "_tap_last"}, 32'(tap_last), 0);
        checkOutput({tag, "_win_row"}, 32'(win_row), 0);
        checkOutput({tag, "_win_col"}, 32'(win_col), 0);
    endtask

    // Every cycle: issued addresses follow window order, accepted taps carry matching data and tags.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                checkOutput("hold_tap_out", 32'(tap_out), 32'(prev_out));
                checkOutput("hold_tap_idx", 32'(tap_idx), 32'(prev_idx));
                checkOutput("hold_win_pos", {28'd0, win_row, win_col}, {28'd0, prev_row, prev_col});
            end
            if (tap_valid) begin
                checkOutput("valid_has_read", 32'(acc_ptr < issue_ptr), 1);
                if (mac_ready) begin
                    checkOutput("tap_out", 32'(tap_out), {16'd0, 8'hA5, 8'(exp_addr(acc_ptr))});
                    checkOutput("tap_idx", 32'(tap_idx), 32'(acc_ptr % (FS * FS)));
                    checkOutput("tap_last", 32'(tap_last), 32'(acc_ptr % (FS * FS) == FS * FS - 1));
                    checkOutput("win_row", 32'(win_row), 32'(acc_ptr / (FS * FS * OS)));
                    checkOutput("win_col", 32'(win_col), 32'((acc_ptr / (FS * FS)) % OS));
                    acc_ptr++;
                end else begin
                    checkOutput("no_issue_when_stalled", 32'(rd_en), 0);
                end
            end
            if (rd_en) begin
                checkOutput("issue_in_range", 32'(issue_ptr < N), 1);
                checkOutput("rd_addr", 32'(rd_addr), 32'(exp_addr(issue_ptr)));
                issue_ptr++;
            end
            if (done) checkOutput("all_taps_delivered", 32'(acc_ptr), N);
            prev_hold = tap_valid && !mac_ready;
            prev_out  = tap_out;
            prev_idx  = tap_idx;
            prev_row  = win_row;
            prev_col  = win_col;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Relative cycle 0 carries the start pulse; other events are placed by cycle number (-1 = none).
    task automatic applyStimulus(input int lo, input int hi, input int ab, input int s2,
                                 input int rs, input int last);
        rd_count = 0; rd_first = -1; last_addr = -1; done_count = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; tv_first = -1; tv_last = -1;
        addr_lo = -1; addr_hi = -2; out_lo = -1; out_hi = -2;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                issue_ptr = 0;
                acc_ptr   = 0;
            end
            start     = (c == 0) || (c == s2);
            abort     = (c == ab);
            mac_ready = !(c >= lo && c <= hi);
            if (c == rs + 2) rst_n = 1'b1;
            if (c == rs) begin
                #2 rst_n = 1'b0;
                #1 checkIdleZero("async_rst");
            end
            @(negedge clk);
            if (rst_n) begin
                if (rd_en) begin
                    if (rd_count < 10) fa[rd_count] = int'(rd_addr);
                    if (rd_first < 0) rd_first = c;
                    rd_count++;
                    last_addr = int'(rd_addr);
                end
                if (busy) begin
                    if (busy_first < 0) busy_first = c;
                    busy_last = c;
                end
                if (tap_valid) begin
                    if (tv_first < 0) tv_first = c;
                    tv_last = c;
                end
                if (done) begin
                    done_count++;
                    done_cyc = c;
                end
                if (c == lo) begin addr_lo = int'(rd_addr); out_lo = int'(tap_out); end
                if (c == hi) begin addr_hi = int'(rd_addr); out_hi = int'(tap_out); end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        mac_ready = 1'b1;
    endtask

    task automatic checkCleanPass(input string tag);
        checkOutput({tag, "_rd_count"}, rd_count, N);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_done_cycle"}, done_cyc, N + 2);
        checkOutput({tag, "_first_addr"}, fa[0], 0);
        checkOutput({tag, "_last_addr"}, last_addr, 35);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mac_ready = 1'b1;
        #2 checkIdleZero("reset");
        #10 rst_n = 1'b1;

        $display("[TB] pass 1: full throughput");
        applyStimulus(-1, -2, -1, -1, -10, 150);
        checkCleanPass("p1");
        checkOutput("p1_addr1", fa[1], 1);
        checkOutput("p1_addr2", fa[2], 2);
        checkOutput("p1_addr3", fa[3], 6);
        checkOutput("p1_addr5", fa[5], 8);
        checkOutput("p1_addr8", fa[8], 14);
        checkOutput("p1_addr9", fa[9], 1);
        checkOutput("p1_rd_first", rd_first, 1);
        checkOutput("p1_busy_first", busy_first, 1);
        checkOutput("p1_busy_last", busy_last, 146);
        checkOutput("p1_tv_first", tv_first, 2);
        checkOutput("p1_tv_last", tv_last, 145);
`ifdef CONV_SCHED_PERF_EN
        checkOutput("p1_stall_cnt", stall_cnt, 0);
`endif

        $display("[TB] pass 2: mac_ready low cycles 10-19");
        applyStimulus(10, 19, -1, -1, -10, 160);
        checkOutput("p2_rd_count", rd_count, N);
        checkOutput("p2_done_count", done_count, 1);
        checkOutput("p2_done_cycle", done_cyc, 156);
        checkOutput("p2_busy_last", busy_last, 156);
        checkOutput("p2_addr_frozen", addr_hi, addr_lo);
        checkOutput("p2_addr_at_stall", addr_lo, 1);
        checkOutput("p2_tap_frozen", out_hi, out_lo);
`ifdef CONV_SCHED_PERF_EN
        checkOutput("p2_stall_cnt", stall_cnt, 10);
`endif

        $display("[TB] start and abort together while idle");
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_beats_start_busy", 32'(busy), 0);
        checkOutput("abort_beats_start_rd_en", 32'(rd_en), 0);

        $display("[TB] pass 3: abort at cycle 50");
        applyStimulus(-1, -2, 50, -1, -10, 60);
        checkOutput("p3_done_count", done_count, 0);
        checkOutput("p3_busy_last", busy_last, 50);
        checkOutput("p3_tv_last", tv_last, 50);
        applyStimulus(-1, -2, -1, -1, -10, 150);
        checkCleanPass("p3r");

        $display("[TB] pass 4: start while busy at cycle 40");
        applyStimulus(-1, -2, -1, 40, -10, 150);
        checkCleanPass("p4");

        $display("[TB] pass 5: async reset at cycle 70");
        applyStimulus(-1, -2, -1, -1, 70, 80);
        checkOutput("p5_done_count", done_count, 0);
        checkOutput("p5_busy_last", busy_last, 69);
        checkOutput("p5_tv_last", tv_last, 69);
        applyStimulus(-1, -2, -1, -1, -10, 150);
        checkCleanPass("p5r");
        checkOutput("p5r_addr3", fa[3], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
